booth_mul_arbiter: RTL

Sequential radix-2 Booth multiplier shared between two requesters. The block round-robin arbitrates between two valid/ready request ports, latches the granted operands, and runs one Booth add/subtract-and-shift step per clock. It returns the signed product with the requester ID on a single valid/ready response channel. It sits in front of the multiply datapath so two client blocks can share one iterative multiplier instead of each instantiating a combinational array.

---
 rtl/booth_mul_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: two-port round-robin front end sharing one radix-2 Booth multiplier
module booth_mul_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_q,
    input  logic [WIDTH-1:0]     req0_m,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_q,
    input  logic [WIDTH-1:0]     req1_m,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             q1_q, q1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             g0, g1;
    logic [WIDTH:0]   ms, am;

    // Grant, Booth step and next-state computation; A is one bit wider so -M cannot overflow
    always_comb begin
        g0         = req0_valid & (~req1_valid | last_q);
        g1         = req1_valid & ~g0;
        req0_ready = (state_q == IDLE) & g0;
        req1_ready = (state_q == IDLE) & g1;
        ms         = {m_q[WIDTH-1], m_q};
        am         = ({qr_q[0], q1_q} == 2'b10) ? a_q - ms :
                     ({qr_q[0], q1_q} == 2'b01) ? a_q + ms : a_q;
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        a_d        = a_q;
        qr_d       = qr_q;
        m_d        = m_q;
        q1_d       = q1_q;
        cnt_d      = cnt_q;
        if (state_q == IDLE) begin
            if (g0 | g1) begin
                qr_d    = g1 ? req1_q : req0_q;
                m_d     = g1 ? req1_m : req0_m;
                id_d    = g1;
                last_d  = g1;
                a_d     = '0;
                q1_d    = 1'b0;
                cnt_d   = CW'(WIDTH);
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            a_d     = {am[WIDTH], am[WIDTH:1]};
            qr_d    = {am[0], qr_q[WIDTH-1:1]};
            q1_d    = qr_q[0];
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_d == '0) ? DONE : RUN;
        end else begin
            state_d = rsp_ready ? IDLE : DONE;
        end
    end

    // Response channel is only driven while a finished product is waiting
    always_comb begin
        rsp_valid  = (state_q == DONE);
        rsp_result = rsp_valid ? {a_q[WIDTH-1:0], qr_q} : '0;
        rsp_id     = rsp_valid & id_q;
        busy       = (state_q != IDLE);
    end

    // State registers; last_grant resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= '0;
            qr_q    <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
